// File: rtl/aexm_regf_mt_if.sv
// Register-file datapath bundle between the pipeline and aexm_regf_mt.
// master = pipeline side, slave = register file side.
interface aexm_regf_mt_if #(
  parameter int RW = 5,
  parameter int TW = 1
);
  logic          gena;
  logic [TW-1:0] rthd;
  logic [TW-1:0] wthd;
  logic [RW-1:0] rRA;
  logic [RW-1:0] rRB;
  logic [RW-1:0] rRD;
  logic [RW-1:0] rRW;
  logic          rWE;
  logic [1:0]    rMXDST;
  logic [31:0]   rRESULT;
  logic [29:0]   rPCLNK;
  logic [3:0]    rDWBSEL;
  logic [1:0]    rOPC;
  logic [31:0]   aexm_dcache_datai;
  logic [31:0]   fsl_dat_i;
  logic [31:0]   rREGA;
  logic [31:0]   rREGB;
  logic [31:0]   rDWBDI;
  logic [31:0]   aexm_dcache_datao;
  logic [31:0]   fsl_dat_o;
  logic          busy;

  modport master (
    output gena, rthd, wthd,
    output rRA, rRB, rRD, rRW,
    output rWE, rMXDST,
    output rRESULT, rPCLNK,
    output rDWBSEL, rOPC,
    output aexm_dcache_datai,
    output fsl_dat_i,
    input  rREGA, rREGB, rDWBDI,
    input  aexm_dcache_datao,
    input  fsl_dat_o, busy
  );

  modport slave (
    input  gena, rthd, wthd,
    input  rRA, rRB, rRD, rRW,
    input  rWE, rMXDST,
    input  rRESULT, rPCLNK,
    input  rDWBSEL, rOPC,
    input  aexm_dcache_datai,
    input  fsl_dat_i,
    output rREGA, rREGB, rDWBDI,
    output aexm_dcache_datao,
    output fsl_dat_o, busy
  );
endinterface

// File: rtl/aexm_regf_mt.sv
// Multi-threaded AEXM register file with load/store sizers and clear sweep.
// Optional write-to-read bypass enabled by defining AEXM_REGF_FWD_EN.
module aexm_regf_mt #(
  parameter int NREG    = 32,
  parameter int THREADS = 2,
  parameter bit ZERO_R0 = 1'b1
) (
  input logic           gclk,
  input logic           grst,
  aexm_regf_mt_if.slave bus
);
  localparam int RW    = $clog2(NREG);
  localparam int TW    = (THREADS > 1) ? $clog2(THREADS) : 1;
  localparam int DEPTH = THREADS * NREG;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic {CLR, RUN} state_t;

  state_t        state;
  state_t        stateNxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNxt;
  logic          busy;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rDWBDO;
  logic [31:0]   xDWBDO;
  logic [31:0]   xWDAT;
  logic [31:0]   xDWBDI;
  logic          wrEn;
  logic [AW-1:0] wAddr;

  logic [TW-1:0] pThd [3];
  logic [RW-1:0] pIdx [3];
  logic [31:0]   pDat [3];

  // Single-thread builds drop the thread bit in the cast.
  function automatic logic [AW-1:0] addrOf(
    input logic [TW-1:0] t,
    input logic [RW-1:0] i
  );
    return AW'({t, i});
  endfunction

  assign busy = (state == CLR);

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state <= CLR;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    unique case (state)
      CLR: begin
        cntNxt = cnt + 1'b1;
        if (cnt == CW'(DEPTH - 1))
          stateNxt = RUN;
      end
      RUN: begin
        stateNxt = RUN;
      end
      default: begin
        stateNxt = CLR;
      end
    endcase
  end

  always_comb begin
    xDWBDI = '0;
    unique case (bus.rDWBSEL)
      4'h8: xDWBDI = {24'h0, bus.aexm_dcache_datai[31:24]};
      4'h4: xDWBDI = {24'h0, bus.aexm_dcache_datai[23:16]};
      4'h2: xDWBDI = {24'h0, bus.aexm_dcache_datai[15:8]};
      4'h1: xDWBDI = {24'h0, bus.aexm_dcache_datai[7:0]};
      4'hC: xDWBDI = {16'h0, bus.aexm_dcache_datai[31:16]};
      4'h3: xDWBDI = {16'h0, bus.aexm_dcache_datai[15:0]};
      4'hF: xDWBDI = bus.aexm_dcache_datai;
      4'h0: xDWBDI = bus.fsl_dat_i;
      default: xDWBDI = '0;
    endcase
  end

  always_comb begin
    xWDAT = '0;
    unique case (bus.rMXDST)
      2'd0: xWDAT = bus.rRESULT;
      2'd1: xWDAT = {bus.rPCLNK, 2'b00};
      2'd2: xWDAT = xDWBDI;
      default: xWDAT = '0;
    endcase
  end

  assign wAddr = addrOf(bus.wthd, bus.rRW);
  assign wrEn  = bus.rWE && bus.gena && !busy &&
                 (bus.rMXDST != 2'd3) &&
                 !(ZERO_R0 && (bus.rRW == '0));

  // Clear sweep owns the write port until RUN.
  always_ff @(posedge gclk) begin
    if (busy)
      mem[cnt[AW-1:0]] <= '0;
    else if (wrEn)
      mem[wAddr] <= xWDAT;
  end

  // Ports: 0 = A, 1 = B, 2 = store data.
  always_comb begin
    pThd[0] = bus.rthd;
    pThd[1] = bus.rthd;
    pThd[2] = bus.rthd;
    pIdx[0] = bus.rRA;
    pIdx[1] = bus.rRB;
    pIdx[2] = bus.rRD;
    for (int p = 0; p < 3; p++) begin
      pDat[p] = mem[addrOf(pThd[p], pIdx[p])];
`ifdef AEXM_REGF_FWD_EN
      if (wrEn && (pThd[p] == bus.wthd) &&
          (pIdx[p] == bus.rRW))
        pDat[p] = xWDAT;
`endif
      if (ZERO_R0 && (pIdx[p] == '0))
        pDat[p] = '0;
    end
  end

  always_comb begin
    xDWBDO = '0;
    unique case (bus.rOPC)
      2'd0: xDWBDO = {4{pDat[2][7:0]}};
      2'd1: xDWBDO = {2{pDat[2][15:0]}};
      2'd2: xDWBDO = pDat[2];
      2'd3: xDWBDO = pDat[0];
      default: xDWBDO = '0;
    endcase
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst)
      rDWBDO <= '0;
    else if (bus.gena && !busy)
      rDWBDO <= xDWBDO;
  end

  assign bus.rREGA             = busy ? '0 : pDat[0];
  assign bus.rREGB             = busy ? '0 : pDat[1];
  assign bus.rDWBDI            = xDWBDI;
  assign bus.aexm_dcache_datao = rDWBDO;
  assign bus.fsl_dat_o         = rDWBDO;
  assign bus.busy              = busy;
endmodule

// File: doc/aexm_regf_mt.md
Name: aexm_regf_mt

Overview:
- Parametrised, multi-threaded successor to the AEXM general-purpose register file.
- Holds THREADS banks of NREG x 32-bit registers and provides two operand read ports plus a store-data read port.
- Includes the load sizer (data cache and FSL), the write-back mux and a registered store sizer.
- Adds a hardware clear sequencer that zeroes every register after reset, and optional write-to-read forwarding.

Parameters:
- NREG, 32, registers per thread; power of two, 2..32; RW = log2(NREG).
- THREADS, 2, hardware thread banks; power of two, 1..4; TW = max(1, log2(THREADS)).
- ZERO_R0, 1, 1 = R0 is hardwired zero (never written, always reads 0); 0 = R0 is an ordinary register.

Ports:
- gclk  in  1  clock; all state updates on the rising edge.
- grst  in  1  asynchronous, active-low reset.
- gena  in  1  pipeline enable; 0 freezes the rDWBDO register and blocks register writes.
- rthd  in  TW  thread index for the read ports (decode stage).
- wthd  in  TW  thread index for the write port (write-back stage).
- rRA, rRB, rRD  in  RW  read indices for operand A, operand B and store data.
- rRW  in  RW  write index.
- rWE  in  1  write request.
- rMXDST  in  2  write-back source select: 0 = rRESULT, 1 = {rPCLNK,2'b00}, 2 = sized load, 3 = no write.
- rRESULT  in  32  ALU result.
- rPCLNK  in  30  link address [31:2].
- rDWBSEL  in  4  load byte-lane select.
- rOPC  in  2  store size: 0 = byte, 1 = half, 2 = word, 3 = FSL.
- aexm_dcache_datai  in  32  load data from the data cache.
- fsl_dat_i  in  32  FSL input data.
- rREGA, rREGB  out  32  operand read data.
- rDWBDI  out  32  sized load data.
- aexm_dcache_datao, fsl_dat_o  out  32  registered store data; both carry the same rDWBDO value.
- busy  out  1  high while the clear sequencer runs.

Behaviour:
- Storage: THREADS*NREG words. Address = {thread, index}.
- Reads are combinational.
- While busy = 1, rREGA and rREGB read as 0.
- With ZERO_R0 = 1, a read of index 0 returns 0 for every thread.
- Write occurs at posedge when all of the following hold: rWE, gena, !busy, rMXDST != 3, and not (ZERO_R0 && rRW == 0).
- Write data xWDAT: rMXDST 0 = rRESULT; 1 = {rPCLNK,2'b00}; 2 = rDWBDI.
- Load sizer (combinational, zero-extended):
  - rDWBSEL 8/4/2/1 = byte [31:24]/[23:16]/[15:8]/[7:0].
  - C = half [31:16]; 3 = half [15:0].
  - F = word.
  - 0 = fsl_dat_i.
  - Any other value = 32'h0; no X is propagated.
- Store sizer: xDWBDO = byte replicated x4 / half replicated x2 / word, taken from the store-data read (rthd, rRD) when rOPC = 0/1/2. rOPC = 3 takes operand A (rthd, rRA).
- rDWBDO <= xDWBDO on posedge when gena && !busy. One-cycle latency from operand index to aexm_dcache_datao.
- Clear FSM: states CLR and RUN.
  - grst low (async): state = CLR, counter = 0, busy = 1, rDWBDO = 0.
  - CLR: each posedge writes 0 to entry counter and increments counter. gena is ignored.
  - When counter == THREADS*NREG-1, that entry is written and the FSM moves to RUN. busy falls on the following edge; CLR lasts exactly THREADS*NREG cycles.
  - RUN: normal operation. Only reset re-enters CLR.
  - Reset asserted mid-clear restarts the sweep from 0.
- Counter width is log2(THREADS*NREG)+1 so the count does not wrap before the compare.
- A write request during CLR is dropped; it is not queued.
- Simultaneous write and read of the same address without forwarding: the read returns the old value and the new value is visible next cycle.

Optional Feature:
- Macro: AEXM_REGF_FWD_EN.
- Defined: any read port (A, B, store data) whose {thread, index} equals the active write {wthd, rRW} in the same cycle returns xWDAT combinationally.
  - The bypass feeds the store sizer too, covering both the FSL and store-data paths.
  - No bypass to index 0 when ZERO_R0 = 1.
  - No bypass when the write is suppressed.
- Undefined: no bypass paths; reads always return array contents.

Test Plan:
- Reset, NREG = 32, THREADS = 2: release grst → busy high for exactly 64 cycles, then low; every register of both threads reads 0.
- Thread isolation: write 32'hDEADBEEF to t0 r5, then 32'h12345678 to t1 r5 → rthd = 0 rRA = 5 gives DEADBEEF; rthd = 1 gives 12345678.
- R0 protection: ZERO_R0 = 1, write 32'hFFFFFFFF to r0 → reads 0. With ZERO_R0 = 0 → reads FFFFFFFF.
- Load sizer:
  - aexm_dcache_datai = 32'hA1B2C3D4, rDWBSEL = 4 → rDWBDI = 32'h000000B2.
  - rDWBSEL = 3 → 32'h0000C3D4.
  - rDWBSEL = 0 with fsl_dat_i = 32'h55 → 32'h00000055.
  - rDWBSEL = 5 → 32'h0.
- Store sizer and stall: r7 = 32'h0000ABCD, rOPC = 0 → next cycle datao = 32'hCDCDCDCD. Hold gena = 0 and change rOPC to 1 → datao stays CDCDCDCD; gena = 1 → ABCDABCD.
- Forwarding, same-cycle write r3 = 32'h77 with rRA = 3: FWD_EN defined → rREGA = 32'h77 that cycle. Undefined → old value that cycle, 32'h77 next cycle.
- Mid-clear reset: assert grst at clear cycle 20 → busy stays high and a fresh 64-cycle sweep starts after release.
